// File: rtl/seq_sub_pkg.sv
// Shared types and default geometry for the sequential subtractor.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_N      = 64;
    localparam int unsigned DEF_W      = 16;
    localparam int unsigned DEF_CHUNKS = DEF_N / DEF_W;

endpackage

// File: rtl/sub_chunk.sv
// Combinational W-bit subtract with borrow in and borrow out.
module sub_chunk #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] full;

    // One extra bit catches the borrow out of the chunk's top bit.
    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        diff = full[W-1:0];
        bout = full[W];
    end

endmodule

// File: rtl/seq_subtractor.sv
// Sequential N-bit subtractor processing W bits per cycle.
// Optional feature macro: SEQ_SUB_SIGNED_MAG_EN (signed negative results are
// reported as magnitude). Undefined: final_diff is always the raw difference.
module seq_subtractor
    import seq_sub_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         signed_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] final_diff,
    output logic         bout,
    output logic         negative_flag,
    output logic         overflow_flag,
    output logic         zero_flag
);

    localparam int unsigned CHUNKS = N / W;
    localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          sg_q, sg_d;
    logic [N-1:0]  raw_q, raw_d;
    logic [N-1:0]  fd_q, fd_d;
    logic          bout_q, bout_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic [W-1:0]  a_chunk, b_chunk, chunk_diff;
    logic          chunk_bout;

    // Present the operand chunk selected by the counter to the shared slice.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (cnt_q == CW'(k)) begin
                a_chunk = a_q[k*W +: W];
                b_chunk = b_q[k*W +: W];
            end
        end
    end

    sub_chunk #(.W(W)) u_sub_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .bin  (borrow_q),
        .diff (chunk_diff),
        .bout (chunk_bout)
    );

    // Next-state, datapath capture and result/flag formation.
    always_comb begin
        logic [N-1:0] fd_v;
        logic         msb;

        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        sg_d     = sg_q;
        raw_d    = raw_q;
        fd_d     = fd_q;
        bout_d   = bout_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        fd_v     = raw_q;
        msb      = raw_q[N-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;  // borrow-in seeds the chain register
                    sg_d     = signed_en;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < CHUNKS; k++) begin
                    if (cnt_q == CW'(k)) begin
                        raw_d[k*W +: W] = chunk_diff;
                    end
                end
                borrow_d = chunk_bout;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                neg_d = sg_q && msb;
`ifdef SEQ_SUB_SIGNED_MAG_EN
                if (sg_q && msb) begin
                    fd_v = ~raw_q + 1'b1;
                end
`endif
                fd_d   = fd_v;
                bout_d = borrow_q;
                ovf_d  = sg_q ? ((a_q[N-1] != b_q[N-1]) && (msb != a_q[N-1]))
                              : borrow_q;
                zero_d = (fd_v == '0);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sg_q     <= 1'b0;
            raw_q    <= '0;
            fd_q     <= '0;
            bout_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sg_q     <= sg_d;
            raw_q    <= raw_d;
            fd_q     <= fd_d;
            bout_q   <= bout_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        in_ready      = (state_q == IDLE);
        out_valid     = (state_q == DONE);
        final_diff    = fd_q;
        bout          = bout_q;
        negative_flag = neg_q;
        overflow_flag = ovf_q;
        zero_flag     = zero_q;
    end

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor (N=64, W=16) against a
// spec-level arithmetic model; honours SEQ_SUB_SIGNED_MAG_EN.
module tb_seq_subtractor;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         bin = 1'b0;
    logic         signed_en = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] final_diff;
    logic         bout, negative_flag, overflow_flag, zero_flag;

    int checks = 0;
    int failures = 0;

    // Model expectations for the operation in flight.
    logic         armed = 1'b0;
    logic [N-1:0] e_fd;
    logic         e_bout, e_neg, e_ovf, e_zero;

    seq_subtractor #(.N(64), .W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .bin           (bin),
        .signed_en     (signed_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .final_diff    (final_diff),
        .bout          (bout),
        .negative_flag (negative_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: plain arithmetic on the full-width operands.
    task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                         input logic mbin, input logic msg);
        logic [N-1:0] raw;
        raw    = ma - mb - N'(mbin);
        e_bout = ({1'b0, mb} + 65'(mbin)) > {1'b0, ma};
        e_fd   = raw;
        e_neg  = msg && raw[N-1];
`ifdef SEQ_SUB_SIGNED_MAG_EN
        if (msg && raw[N-1]) e_fd = -raw;
`endif
        e_ovf  = msg ? ((ma[N-1] != mb[N-1]) && (raw[N-1] != ma[N-1])) : e_bout;
        e_zero = (e_fd == 0);
    endtask

    // Every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!armed) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                chk("mon_final_diff", final_diff, e_fd);
                chk("mon_bout", 64'(bout), 64'(e_bout));
                chk("mon_negative", 64'(negative_flag), 64'(e_neg));
                chk("mon_overflow", 64'(overflow_flag), 64'(e_ovf));
                chk("mon_zero", 64'(zero_flag), 64'(e_zero));
                chk("mon_in_ready_low", 64'(in_ready), 64'(0));
            end
        end
    end

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tbin, input logic tsg, input int stall,
                          output logic [N-1:0] fd, output logic [3:0] fl);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a = ta; b = tb; bin = tbin; signed_en = tsg; in_valid = 1'b1;
        model(ta, tb, tbin, tsg);
        armed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Inputs are ignored after the accept edge.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        bin = 1'($urandom); signed_en = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'(5));
        fd = final_diff;
        fl = {bout, negative_flag, overflow_flag, zero_flag};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;  // must not be taken on the release edge
        @(posedge clk); #1;
        armed = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_release_in_ready", 64'(in_ready), 64'(1));
        chk("post_release_out_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [N-1:0] fd;
        logic [3:0]   fl;   // {bout, neg, ovf, zero}

        #23;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_final_diff", final_diff, 64'(0));
        chk("rst_flags", 64'({bout, negative_flag, overflow_flag, zero_flag}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(64'd10, 64'd3, 1'b0, 1'b0, 0, fd, fl);
        chk("u10m3_fd", fd, 64'd7);
        chk("u10m3_fl", 64'(fl), 64'(4'b0000));

        run_op(64'd3, 64'd10, 1'b0, 1'b0, 1, fd, fl);
        chk("u3m10_fd", fd, 64'hFFFF_FFFF_FFFF_FFF9);
        chk("u3m10_fl", 64'(fl), 64'(4'b1010));

        run_op(64'd3, 64'd10, 1'b0, 1'b1, 0, fd, fl);
`ifdef SEQ_SUB_SIGNED_MAG_EN
        chk("s3m10_fd", fd, 64'd7);
`else
        chk("s3m10_fd", fd, 64'hFFFF_FFFF_FFFF_FFF9);
`endif
        chk("s3m10_fl", 64'(fl), 64'(4'b1100));

        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0, fd, fl);
        chk("smin_m1_fd", fd, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("smin_m1_fl", 64'(fl), 64'(4'b0010));

        run_op(64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, fd, fl);
        chk("s0_mmin_fd", fd, 64'h8000_0000_0000_0000);
        chk("s0_mmin_fl", 64'(fl), 64'(4'b1110));

        run_op(64'd5, 64'd5, 1'b0, 1'b0, 0, fd, fl);
        chk("u5m5_fd", fd, 64'd0);
        chk("u5m5_zero", 64'(fl[0]), 64'(1));

        run_op(64'd5, 64'd4, 1'b1, 1'b0, 0, fd, fl);
        chk("u5m4b_fd", fd, 64'd0);
        chk("u5m4b_zero", 64'(fl[0]), 64'(1));

        run_op(64'h1_0000, 64'd1, 1'b0, 1'b0, 0, fd, fl);
        chk("xchunk_fd", fd, 64'hFFFF);

        // Long stall: monitor checks outputs every DONE cycle.
        run_op(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1, 10, fd, fl);

        // Randomized operations with occasional boundary operands.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = 64'h8000_0000_0000_0000;
                1: rb = ra;
                2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                3: ra = {48'd0, ra[15:0]};
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), fd, fl);
        end

        // Reset mid-RUN must discard the operation and clear outputs.
        while (!in_ready) begin @(posedge clk); #1; end
        a = 64'd100; b = 64'd1; bin = 1'b0; signed_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_final_diff", final_diff, 64'(0));
        chk("midrst_flags", 64'({bout, negative_flag, overflow_flag, zero_flag}), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("after_rst_no_valid", 64'(out_valid), 64'(0));
        end

        run_op(64'd10, 64'd3, 1'b0, 1'b0, 0, fd, fl);
        chk("after_rst_op_fd", fd, 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 Parameter N, default 64, operand/result width.
REQ-002 Parameter W, default 16, chunk width processed per cycle; N SHALL be an integer multiple of W.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 a, b  input  N  minuend, subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 signed_en  input  1  two's-complement interpretation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 final_diff  output  N  result (magnitude when signed and negative).
REQ-013 bout  output  1  borrow-out of raw difference.
REQ-014 negative_flag, overflow_flag, zero_flag  output  1 each  status flags.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIX, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE->RUN on in_valid&&in_ready; a, b, bin, signed_en SHALL be captured on that edge.
REQ-017 RUN: each cycle computes chunk k (bits k*W+W-1..k*W) of raw = a-b-bin, borrow chained between chunks via a registered borrow; k counts 0..N/W-1, then RUN->FIX.
REQ-018 FIX (one cycle) SHALL register final_diff and all flags; FIX->DONE.
REQ-019 Latency: out_valid SHALL rise exactly N/W+1 cycles after the accept edge (5 for N=64, W=16).
REQ-020 DONE holds all outputs stable until out_valid&&out_ready, then ->IDLE; new operands SHALL NOT be accepted in the same cycle.
REQ-021 bout SHALL equal the borrow out of bit N-1 in both modes.
REQ-022 Unsigned (signed_en=0): final_diff=raw, negative_flag=0, overflow_flag=bout.
REQ-023 Signed, raw[N-1]=1: final_diff=(~raw)+1 truncated to N bits, negative_flag=1; raw=100..0 yields final_diff=100..0.
REQ-024 Signed, raw[N-1]=0: final_diff=raw, negative_flag=0.
REQ-025 Signed overflow_flag=(a[N-1]!=b[N-1])&&(raw[N-1]!=a[N-1]), independent of magnitude conversion.
REQ-026 zero_flag=(final_diff==0).
REQ-027 Inputs other than in_valid/out_ready SHALL be ignored outside the accept edge.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, chunk counter 0, borrow register 0, final_diff 0, all flags 0, bout 0, out_valid 0; in_ready 1.
REQ-029 Reset during RUN/FIX/DONE SHALL discard the operation; no out_valid after release until a new accept.

Configuration
REQ-030 Macro SEQ_SUB_SIGNED_MAG_EN defined: REQ-023 applies.
REQ-031 Macro undefined: final_diff=raw always, negative_flag=signed_en&&raw[N-1]; all other behaviour, flags and latency unchanged.

Structure
REQ-032 Package seq_sub_pkg SHALL hold the FSM state enum and default N, W, and CHUNKS=N/W constants.
REQ-033 One sub-module, sub_chunk: combinational W-bit subtract with borrow in/out, instantiated once and reused per cycle.

Verification (N=64, W=16)
REQ-034 Unsigned 10-3, bin=0 -> final_diff=7, bout=0, all flags 0, out_valid exactly 5 cycles after accept.
REQ-035 Unsigned 3-10 -> final_diff=0xFFFF_FFFF_FFFF_FFF9, bout=1, overflow_flag=1, negative_flag=0.
REQ-036 Signed 3-10 -> final_diff=7, negative_flag=1, overflow_flag=0, bout=1; without macro final_diff=0xFFFF_FFFF_FFFF_FFF9.
REQ-037 Signed 0x8000_0000_0000_0000-1 -> final_diff=0x7FFF_FFFF_FFFF_FFFF, overflow_flag=1, negative_flag=0; signed 0-0x8000_0000_0000_0000 -> final_diff=0x8000_0000_0000_0000, negative_flag=1, overflow_flag=1.
REQ-038 5-5 bin=0 and 5-4 bin=1 -> final_diff=0, zero_flag=1; cross-chunk borrow 0x1_0000-1 -> 0xFFFF.
REQ-039 out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0; rst_n pulsed mid-RUN -> outputs cleared, no out_valid until next accept.
